// File: rtl/uart_tx.sv
// uart_tx: FIFO-buffered UART transmitter, LSB-first with optional parity and 1-2 stop bits
module uart_tx #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic [DATA_BITS-1:0] data_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    output logic                 tx_o,
    output logic                 busy_o,
    output logic                 done_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    typedef enum logic [2:0] {IDLE, ARM, START, DATA, PAR, STOP} state_t;
    state_t state, state_n;
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0] cnt;
    logic [DATA_BITS-1:0] shreg, shreg_n, head;
    logic [2:0] bit_cnt, bit_n;
    logic stop_cnt, stop_n, par, par_n, head_par, tx_n, pop, push, empty, full;
    assign empty    = cnt == '0;
    assign full     = cnt == (AW+1)'(FIFO_DEPTH);
    assign push     = valid_i && !full;
    assign ready_o  = !full;
    assign busy_o   = state != IDLE || !empty;
    assign head     = mem[rptr];
    assign head_par = (^head) ^ (PARITY == 2);
    // FIFO storage; contents need no reset since occupancy is tracked by cnt
    always_ff @(posedge clk)
        if (push) mem[wptr] <= data_i;
    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop) rptr <= rptr + AW'(1);
            cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
    // frame state register; tx_o is registered so the line never glitches
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            par      <= 1'b0;
            tx_o     <= 1'b1;
        end else begin
            state    <= state_n;
            shreg    <= shreg_n;
            bit_cnt  <= bit_n;
            stop_cnt <= stop_n;
            par      <= par_n;
            tx_o     <= tx_n;
        end
    end
    // next-state logic; parity is latched at pop time from the unshifted byte
    always_comb begin
        state_n = state;
        shreg_n = shreg;
        bit_n   = bit_cnt;
        stop_n  = stop_cnt;
        par_n   = par;
        tx_n    = tx_o;
        pop     = 1'b0;
        done_o  = 1'b0;
        case (state)
            IDLE: begin
                tx_n = 1'b1;
                if (!empty) begin
                    pop     = 1'b1;
                    shreg_n = head;
                    par_n   = head_par;
                    bit_n   = '0;
                    state_n = ARM;
                end
            end
            ARM: if (tick) begin
                state_n = START;
                tx_n    = 1'b0;
            end
            START: if (tick) begin
                state_n = DATA;
                tx_n    = shreg[0];
            end
            DATA: if (tick) begin
                shreg_n = shreg >> 1;
                if (bit_cnt == 3'(DATA_BITS - 1)) begin
                    state_n = PARITY != 0 ? PAR : STOP;
                    tx_n    = PARITY != 0 ? par : 1'b1;
                    stop_n  = 1'b0;
                end else begin
                    bit_n = bit_cnt + 3'd1;
                    tx_n  = shreg[1];
                end
            end
            PAR: if (tick) begin
                state_n = STOP;
                tx_n    = 1'b1;
                stop_n  = 1'b0;
            end
            STOP: if (tick) begin
                if (stop_cnt != 1'(STOP_BITS - 1)) begin
                    stop_n = 1'b1;
                end else begin
                    done_o = 1'b1;
                    if (!empty) begin
                        pop     = 1'b1;
                        shreg_n = head;
                        par_n   = head_par;
                        bit_n   = '0;
                        state_n = START;
                        tx_n    = 1'b0;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmitter; the transmit-side counterpart of the team's UART receiver, sharing the same external baud-tick generator. One tick equals one bit period.
- A small input FIFO accepts bytes over a valid/ready handshake. The block serialises them LSB-first as start bit, data, optional parity, then stop bit(s).
- Frames go back-to-back with no idle gap while the FIFO holds data.
- Sits between the host/bus logic and the tx pin.

Parameters:
- DATA_BITS, 8, data bits per frame, legal 5..8.
- PARITY, 0, 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, legal 1 or 2.
- FIFO_DEPTH, 4, input FIFO entries, power of 2, >= 2.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- tick  input  1  one-cycle baud pulse, one per bit period, free-running.
- data_i  input  DATA_BITS  byte to send.
- valid_i  input  1  data_i valid.
- ready_o  output  1  FIFO can accept; equals !full.
- tx_o  output  1  serial line, idle high, registered.
- busy_o  output  1  high when state != IDLE or FIFO not empty.
- done_o  output  1  one-cycle pulse at the end of each frame's last stop bit.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE, FIFO emptied, tx_o=1, ready_o=1, busy_o=0, done_o=0.
  - Bit and stop counters cleared.
  - A frame in flight is abandoned; tx_o returns to 1 on the next edge.
- Push: occurs when valid_i && ready_o at a clk edge.
  - ready_o depends only on full; a same-cycle pop does not raise it.
  - There is no bypass: a byte pushed into an empty FIFO is popped no earlier than the next cycle.
- Pop: occurs only on the FIFO-to-shift-register transfers defined below.
- Simultaneous push and pop at non-full, non-empty: both take effect; count unchanged.
- FIFO pointers wrap modulo FIFO_DEPTH.
- States: IDLE, ARM, START, DATA, PAR, STOP.
- IDLE:
  - tx_o=1.
  - If the FIFO is non-empty: pop into shreg, bit_cnt=0, go to ARM. A tick in this same cycle is ignored.
- ARM: on tick, go to START and set tx_o=0. This guarantees a full-width start bit.
- START: on tick, go to DATA and set tx_o=shreg[0].
- DATA: on tick, shift shreg right.
  - If bit_cnt==DATA_BITS-1: if PARITY!=0, go to PAR with tx_o=parity bit; otherwise go to STOP with tx_o=1, stop_cnt=0.
  - Otherwise: bit_cnt+1 and tx_o=next bit.
- Parity bit:
  - Even: XOR of the popped data bits.
  - Odd: inverse of that XOR.
  - Computed from the byte as popped, not from the shifted register.
- PAR: on tick, go to STOP with tx_o=1, stop_cnt=0.
- STOP: on tick:
  - If stop_cnt < STOP_BITS-1: stop_cnt+1, stay in STOP.
  - Otherwise: done_o=1 for that cycle, and then:
    - FIFO non-empty: pop, go directly to START with tx_o=0 (no gap).
    - FIFO empty: go to IDLE.
- Between ticks, every state holds and tx_o is stable.
- Latency: start-bit falling edge occurs on the first tick strictly after the cycle following the push into an empty, idle block.
- Line view: each bit, including each stop bit, lasts exactly one tick period.
- done_o count equals the count of accepted bytes.
- DATA_BITS<8: data_i upper bits do not exist; width follows the parameter.

Test Plan:
- Reset then idle, tick every 16 clk → tx_o=1, ready_o=1, busy_o=0, no done_o pulse for 1000 cycles.
- PARITY=0, STOP_BITS=1, push 0xA5 → tx_o per tick period is 0,1,0,1,0,0,1,0,1,1. Exactly one done_o pulse. Then busy_o=0 and tx_o=1.
- Even parity, push 0xA5 → parity bit 0. Odd parity, push 0xA5 → parity bit 1. Odd parity, push 0x01 → parity bit 0. Each frame is 11 bit periods.
- Push 0x55, 0xFF, 0x00, 0x3C, 0x81 back-to-back while holding valid_i → ready_o drops after the FIFO fills. All 5 bytes are sent with no high gap between one stop bit and the next start bit. 5 done_o pulses.
- STOP_BITS=2, push 0x00 → 0, eight 0s, then 1 lasting exactly 2 tick periods before done_o.
- Assert rst mid-DATA of 0xC3 with 2 bytes queued → next edge: tx_o=1, FIFO empty, ready_o=1. After release, no further frames are sent.
